// File: rtl/midi_synth_pkg.sv
// Shared types and constants for the MIDI voice scheduling path.
package midi_synth_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOOKUP = 1'b1
   } state_t;

   localparam int         KEY_W        = 8;
   localparam int         VEL_W        = 8;
   localparam logic [7:0] MIDI_NOTE_ON = 8'h90;
   localparam logic [7:0] VEL_RELEASE  = 8'd0;

endpackage

// File: rtl/voice_pick.sv
// Find-first-set: reports whether any bit of vec is set and the lowest such index.
module voice_pick #(
   parameter int NUM_VOICES = 4,
   parameter int VW         = 2
) (
   input  logic [NUM_VOICES-1:0] vec,
   output logic                  found,
   output logic [VW-1:0]         idx
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (vec[i]) begin
            found = 1'b1;
            idx   = VW'(i);
         end
      end
   end

endmodule

// File: rtl/midi_voice_allocator.sv
// Pops note events from the MIDI FIFO and assigns them to synth voices:
// release, retrigger, allocate-free or round-robin steal.
module midi_voice_allocator
   import midi_synth_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int VW         = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    fifo_empty,
   output logic                    fifo_rd,
   input  logic [KEY_W-1:0]        key,
   input  logic [VEL_W-1:0]        velocity,
   input  logic                    panic,
   output logic [8*NUM_VOICES-1:0] voice_key,
   output logic [8*NUM_VOICES-1:0] voice_vel,
   output logic [NUM_VOICES-1:0]   voice_gate,
   output logic [NUM_VOICES-1:0]   voice_trig,
   output logic                    steal
);

   state_t                               state, state_nxt;
   logic [NUM_VOICES-1:0][KEY_W-1:0]     keys;
   logic [NUM_VOICES-1:0][VEL_W-1:0]     vels;
   logic [NUM_VOICES-1:0]                gate;
   logic [NUM_VOICES-1:0]                trig;
   logic                                 steal_q;
   logic [VW-1:0]                        steal_ptr;
   logic [NUM_VOICES-1:0]                match;
   logic                                 free_found, hit_found;
   logic [VW-1:0]                        free_idx, hit_idx;

   genvar g;
   generate
      for (g = 0; g < NUM_VOICES; g++) begin : g_match
         assign match[g] = (keys[g] == key);
      end
   endgenerate

   voice_pick #(.NUM_VOICES(NUM_VOICES), .VW(VW)) u_free (
      .vec   (~gate),
      .found (free_found),
      .idx   (free_idx)
   );

   voice_pick #(.NUM_VOICES(NUM_VOICES), .VW(VW)) u_hit (
      .vec   (match & gate),
      .found (hit_found),
      .idx   (hit_idx)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Pop decision; depends only on state, FIFO flag and panic (never on key/velocity).
   always_comb begin
      state_nxt = state;
      fifo_rd   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rst_n && !fifo_empty && !panic) begin
               fifo_rd   = 1'b1;
               state_nxt = ST_LOOKUP;
            end
         end
         ST_LOOKUP: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Voice bank update on the LOOKUP cycle; panic overrides and drops the popped event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         keys      <= '0;
         vels      <= '0;
         gate      <= '0;
         trig      <= '0;
         steal_q   <= 1'b0;
         steal_ptr <= '0;
      end else begin
         trig    <= '0;
         steal_q <= 1'b0;
         if (panic) begin
            gate <= '0;
         end else if (state == ST_LOOKUP) begin
            if (velocity == VEL_RELEASE) begin
               // Key/velocity stay put so the envelope release phase still sees them.
               gate <= gate & ~(match & gate);
            end else if (hit_found) begin
               vels[hit_idx] <= velocity;
               trig[hit_idx] <= 1'b1;
            end else if (free_found) begin
               keys[free_idx] <= key;
               vels[free_idx] <= velocity;
               gate[free_idx] <= 1'b1;
               trig[free_idx] <= 1'b1;
            end else begin
               keys[steal_ptr] <= key;
               vels[steal_ptr] <= velocity;
               trig[steal_ptr] <= 1'b1;
               steal_q         <= 1'b1;
               steal_ptr       <= (steal_ptr == VW'(NUM_VOICES - 1)) ? '0 : steal_ptr + 1'b1;
            end
         end
      end
   end

   assign voice_key  = keys;
   assign voice_vel  = vels;
   assign voice_gate = gate;
   assign voice_trig = trig;
   assign steal      = steal_q;

endmodule
